// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and constants for the systolic matmul sequencer
package tpu_pkg;

    localparam int P_DEFAULT     = 4;
    localparam int DRAIN_DEFAULT = 2 * P_DEFAULT;

    // Opcodes understood by the CFU command FSM
    typedef enum logic [1:0] {
        CMD_RESET     = 2'd0,
        CMD_WRITE_MEM = 2'd1,
        CMD_COMPUTE   = 2'd2,
        CMD_READ_MEM  = 2'd3
    } cfu_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_WRITE  = 3'd4,
        S_FINISH = 3'd5
    } tpu_state_t;

    // Number of P-wide tiles needed to cover a dimension
    function automatic logic [7:0] ceil_div(input logic [7:0] v, input int p);
        int t;
        t = (int'(v) + p - 1) / p;
        return t[7:0];
    endfunction

endpackage

// File: rtl/tpu_addr_gen.sv
// rtl/tpu_addr_gen.sv - base/offset index counters for the A, B and C buffers
module tpu_addr_gen #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 tile_start,
    input  logic                 step,
    input  logic                 advance,
    input  logic                 col_wrap,
    input  logic                 c_step,
    input  logic [7:0]           stride,
    output logic [ADDR_BITS-1:0] a_index,
    output logic [ADDR_BITS-1:0] b_index,
    output logic [ADDR_BITS-1:0] c_index
);

    logic [ADDR_BITS-1:0] a_base;
    logic [ADDR_BITS-1:0] b_base;
    logic [ADDR_BITS-1:0] stride_ext;

    assign stride_ext = ADDR_BITS'(stride);

    // Tile bases: B advances by K per column tile, A by K per row tile when columns wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_base <= '0;
            b_base <= '0;
        end else if (load) begin
            a_base <= '0;
            b_base <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                b_base <= '0;
                a_base <= a_base + stride_ext;
            end else begin
                b_base <= b_base + stride_ext;
            end
        end
    end

    // Operand indices restart at the tile base and walk k; they hold once stepping stops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_index <= '0;
            b_index <= '0;
        end else if (load) begin
            a_index <= '0;
            b_index <= '0;
        end else if (tile_start) begin
            a_index <= a_base;
            b_index <= b_base;
        end else if (step) begin
            a_index <= a_index + 1'b1;
            b_index <= b_index + 1'b1;
        end
    end

    // C index is contiguous across tiles because tiles are visited in C layout order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_index <= '0;
        end else if (load) begin
            c_index <= '0;
        end else if (c_step) begin
            c_index <= c_index + 1'b1;
        end
    end

endmodule

// File: rtl/tpu_ctrl.sv
// rtl/tpu_ctrl.sv - systolic matmul tile sequencer (optional busy-cycle counter: TPU_CTRL_PERF_EN)
module tpu_ctrl
    import tpu_pkg::*;
#(
    parameter int P         = P_DEFAULT,
    parameter int ADDR_BITS = 16,
    parameter int DRAIN     = 2 * P
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           M,
    input  logic [7:0]           K,
    input  logic [7:0]           N,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] A_index,
    output logic [ADDR_BITS-1:0] B_index,
    output logic                 pe_clear,
    output logic                 pe_in_valid,
    output logic [$clog2(P)-1:0] row_sel,
    output logic                 C_wr_en,
    output logic [ADDR_BITS-1:0] C_index,
    output logic [31:0]          perf_cycles
);

    localparam int RS_W = $clog2(P);

    tpu_state_t state;
    tpu_state_t state_next;

    logic [7:0]  k_r;
    logic [7:0]  mt_last;
    logic [7:0]  nt_last;
    logic [7:0]  mt;
    logic [7:0]  nt;
    logic [15:0] cnt;

    logic accept;
    logic zero_dim;
    logic last_feed;
    logic last_drain;
    logic last_row;
    logic last_nt;
    logic last_mt;

    logic ag_load;
    logic ag_tile;
    logic ag_step;
    logic ag_adv;
    logic ag_cstep;

    assign accept     = (state == S_IDLE) && in_valid;
    assign zero_dim   = (M == 8'd0) || (K == 8'd0) || (N == 8'd0);
    assign last_feed  = (cnt == 16'(k_r) - 16'd1);
    assign last_drain = (cnt == 16'(DRAIN - 1));
    assign last_row   = (row_sel == RS_W'(P - 1));
    assign last_nt    = (nt == nt_last);
    assign last_mt    = (mt == mt_last);

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FINISH);
    assign pe_clear = (state == S_CLEAR);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and address-generator controls
    always_comb begin
        state_next = state;
        ag_load    = 1'b0;
        ag_tile    = 1'b0;
        ag_step    = 1'b0;
        ag_adv     = 1'b0;
        ag_cstep   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    ag_load    = 1'b1;
                    state_next = zero_dim ? S_FINISH : S_CLEAR;
                end
            end
            S_CLEAR: begin
                ag_tile    = 1'b1;
                state_next = S_FEED;
            end
            S_FEED: begin
                if (last_feed) begin
                    state_next = S_DRAIN;
                end else begin
                    ag_step = 1'b1;
                end
            end
            S_DRAIN: begin
                if (last_drain) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                ag_cstep = 1'b1;
                if (last_row) begin
                    ag_adv     = 1'b1;
                    state_next = (last_nt && last_mt) ? S_FINISH : S_CLEAR;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Phase length counter, restarted on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state_next != state) || (state == S_IDLE)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Command dims latched on acceptance; only K and the tile counts are needed afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r     <= '0;
            mt_last <= '0;
            nt_last <= '0;
        end else if (accept) begin
            k_r     <= K;
            mt_last <= ceil_div(M, P) - 8'd1;
            nt_last <= ceil_div(N, P) - 8'd1;
        end
    end

    // Tile position: nt inner, mt outer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mt <= '0;
            nt <= '0;
        end else if (accept) begin
            mt <= '0;
            nt <= '0;
        end else if (ag_adv) begin
            if (last_nt) begin
                nt <= '0;
                mt <= mt + 8'd1;
            end else begin
                nt <= nt + 8'd1;
            end
        end
    end

    // Registered PE/C strobes; pe_in_valid lags FEED by the buffer read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_in_valid <= 1'b0;
            C_wr_en     <= 1'b0;
            row_sel     <= '0;
        end else begin
            pe_in_valid <= (state == S_FEED);
            C_wr_en     <= (state_next == S_WRITE);
            if ((state_next == S_WRITE) && (state == S_WRITE)) begin
                row_sel <= row_sel + 1'b1;
            end else begin
                row_sel <= '0;
            end
        end
    end

    tpu_addr_gen #(
        .ADDR_BITS(ADDR_BITS)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ag_load),
        .tile_start(ag_tile),
        .step      (ag_step),
        .advance   (ag_adv),
        .col_wrap  (last_nt),
        .c_step    (ag_cstep),
        .stride    (k_r),
        .a_index   (A_index),
        .b_index   (B_index),
        .c_index   (C_index)
    );

`ifdef TPU_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: cleared on acceptance, saturating, holds while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
